// File: rtl/fp_cmp_arbiter.sv
// Round-robin arbiter sharing one pipelined FP greater-than comparator among NUM_REQ requesters.
// Optional macro FP_CMP_ARB_NAN_BYPASS_EN forces results of NaN compares to zero.
module fp_cmp_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CMP_LATENCY = 1,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_value1,
    input  logic [NUM_REQ*DATA_W-1:0]    req_value2,
    output logic [DATA_W-1:0]            cmp_value1,
    output logic [DATA_W-1:0]            cmp_value2,
    input  logic [DATA_W-1:0]            cmp_result,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [DATA_W-1:0]            resp_result
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        scan_idx;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_any;
    logic [NUM_REQ-1:0]     grant;
    logic [DATA_W-1:0]      grant_value1;
    logic [DATA_W-1:0]      grant_value2;

    logic [CMP_LATENCY-1:0] tag_valid_q;
    logic [ID_W-1:0]        tag_id_q [CMP_LATENCY];
    logic [DATA_W-1:0]      resp_data;

    // Scan from the pointer, wrapping modulo NUM_REQ; first asserted valid wins.
    always_comb begin
        scan_idx  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
        grant = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
    end

    // Ready is combinational, so hold it low while reset is asserted.
    assign req_ready    = aresetn ? grant : '0;
    assign grant_value1 = req_value1[grant_id*DATA_W +: DATA_W];
    assign grant_value2 = req_value2[grant_id*DATA_W +: DATA_W];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q      <= '0;
            cmp_value1 <= '0;
            cmp_value2 <= '0;
        end else if (grant_any) begin
            ptr_q      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            cmp_value1 <= grant_value1;
            cmp_value2 <= grant_value2;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_valid_q <= '0;
            for (int i = 0; i < CMP_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= grant_any;
            tag_id_q[0]    <= grant_id;
            for (int i = 1; i < CMP_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
        end
    end

`ifdef FP_CMP_ARB_NAN_BYPASS_EN
    logic [CMP_LATENCY-1:0] tag_nan_q;
    logic                   grant_nan;

    function automatic logic is_nan(input logic [DATA_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    assign grant_nan = is_nan(grant_value1) || is_nan(grant_value2);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_nan_q <= '0;
        end else begin
            tag_nan_q[0] <= grant_nan;
            for (int i = 1; i < CMP_LATENCY; i++) begin
                tag_nan_q[i] <= tag_nan_q[i-1];
            end
        end
    end

    // NaN is unordered, so the compare is reported as "not greater".
    assign resp_data = tag_nan_q[CMP_LATENCY-1] ? '0 : cmp_result;
`else
    assign resp_data = cmp_result;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resp_valid  <= '0;
            resp_id     <= '0;
            resp_result <= '0;
        end else if (tag_valid_q[CMP_LATENCY-1]) begin
            resp_valid  <= NUM_REQ'(1) << tag_id_q[CMP_LATENCY-1];
            resp_id     <= tag_id_q[CMP_LATENCY-1];
            resp_result <= resp_data;
        end else begin
            resp_valid  <= '0;
        end
    end

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Self-checking bench for fp_cmp_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (NUM_REQ=4, CMP_LATENCY=1).
module tb_fp_cmp_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_value1;
    logic [N*W-1:0] req_value2;
    logic [W-1:0]   cmp_value1;
    logic [W-1:0]   cmp_value2;
    logic [W-1:0]   cmp_result;
    logic [N-1:0]   resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    fp_cmp_arbiter #(.NUM_REQ(N), .CMP_LATENCY(1), .DATA_W(W)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_value1  (req_value1),
        .req_value2  (req_value2),
        .cmp_value1  (cmp_value1),
        .cmp_value2  (cmp_value2),
        .cmp_result  (cmp_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        if (is_nan(a) || is_nan(b)) return 1'b0;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        return ka > kb;
    endfunction

    // Comparator stub: bit 0 is a > b, upper bits fingerprint the operands so misrouting shows.
    function automatic logic [31:0] cmp_stub(input logic [31:0] a, input logic [31:0] b);
        return {a[31:16] ^ b[15:0], 15'd0, fp_gt(a, b)};
    endfunction

    assign cmp_result = cmp_stub(cmp_value1, cmp_value2);

    function automatic logic [31:0] expected_result(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_CMP_ARB_NAN_BYPASS_EN
        if (is_nan(a) || is_nan(b)) return 32'h0;
`endif
        return cmp_stub(a, b);
    endfunction

    function automatic logic [31:0] rand_fp();
        case ($urandom_range(0, 5))
            0:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            1:       return {1'($urandom), 8'hFF, 23'd0};
            2:       return {1'($urandom), 31'd0};
            3:       return 32'h3F800000 + 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Reference model: pending responses in grant order with the cycle they become visible.
    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    int          ptr_m, cyc, last_id;
    logic [31:0] iss_v1, iss_v2, last_res;
    logic [N-1:0] exp_ready, exp_rv;
    logic [31:0] exp_res, exp_cv1, exp_cv2;
    int          exp_id;

    task automatic model_reset();
        ptr_m = 0; cyc = 0; last_id = 0;
        iss_v1 = '0; iss_v2 = '0; last_res = '0;
        pend_q.delete();
    endtask

    task automatic model_cycle();
        int g;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr_m + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = (g < 0) ? '0 : (N'(1) << g);
        exp_cv1 = iss_v1;
        exp_cv2 = iss_v2;
        exp_rv = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            exp_rv   = N'(1) << pend_q[0].id;
            last_id  = pend_q[0].id;
            last_res = pend_q[0].res;
            void'(pend_q.pop_front());
        end
        exp_id  = last_id;
        exp_res = last_res;
        if (g >= 0) begin
            iss_v1 = req_value1[g*W +: W];
            iss_v2 = req_value2[g*W +: W];
            pend_q.push_back('{id: g, res: expected_result(iss_v1, iss_v2), due: cyc + 2});
            ptr_m = (g + 1) % N;
        end
        cyc++;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        req_valid = '0;
        req_value1 = '0;
        req_value2 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            checks++;
            if (req_ready !== '0 || resp_valid !== '0) begin
                errors++;
                $display("FAIL reset_strobes c=%0d: ready=%b resp_valid=%b, required 0", c,
                         req_ready, resp_valid);
            end
            checks++;
            if (cmp_value1 !== '0 || cmp_value2 !== '0 || resp_id !== '0 || resp_result !== '0) begin
                errors++;
                $display("FAIL reset_values c=%0d: cmp=%h/%h id=%0d res=%h, required 0", c,
                         cmp_value1, cmp_value2, resp_id, resp_result);
            end
            @(posedge aclk);
            #1 if (c == 2) aresetn = 1'b1;
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_value1[2*W +: W] = 32'h40200000;
        req_value2[2*W +: W] = 32'h3fc00000;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b required 0100", req_ready);
        end
        @(posedge aclk);
        #1 req_valid = '0;
        @(negedge aclk);
        checks++;
        if (cmp_value1 !== 32'h40200000 || cmp_value2 !== 32'h3fc00000) begin
            errors++;
            $display("FAIL single_cmp_value: got %h/%h required 40200000/3fc00000",
                     cmp_value1, cmp_value2);
        end
        @(negedge aclk);
        checks++;
        if (resp_valid !== 4'b0100 || resp_id !== 2'd2 || resp_result !== 32'h40200001) begin
            errors++;
            $display("FAIL single_resp: got %b/%0d/%h required 0100/2/40200001",
                     resp_valid, resp_id, resp_result);
        end
        @(negedge aclk);
        checks++;
        if (resp_valid !== '0) begin
            errors++;
            $display("FAIL single_resp_pulse: got %b required 0000", resp_valid);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < N; i++) begin
                req_value1[i*W +: W] = rand_fp();
                req_value2[i*W +: W] = rand_fp();
            end
            @(negedge aclk);
            checks++;
            if (req_ready !== ((k < 8) ? (4'(1) << (k % 4)) : 4'b0000)) begin
                errors++;
                $display("FAIL rr_grant k=%0d: got %b required %b", k, req_ready,
                         (k < 8) ? (4'(1) << (k % 4)) : 4'b0000);
            end
            checks++;
            if (resp_valid !== ((k >= 2) ? (4'(1) << ((k - 2) % 4)) : 4'b0000)) begin
                errors++;
                $display("FAIL rr_resp k=%0d: got %b required %b", k, resp_valid,
                         (k >= 2) ? (4'(1) << ((k - 2) % 4)) : 4'b0000);
            end
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req_valid = (k == 0) ? 4'b0010 : 4'b1010;
            want = (k == 0 || k % 2 == 0) ? 4'b0010 : 4'b1000;
            @(negedge aclk);
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL fair_grant k=%0d: got %b required %b", k, req_ready, want);
            end
            @(posedge aclk);
            #1;
        end
        req_valid = '0;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_nan();
        logic [31:0] want;
`ifdef FP_CMP_ARB_NAN_BYPASS_EN
        want = 32'h0;
`else
        want = 32'h7fc00000;
`endif
        do_reset();
        req_valid = 4'b0001;
        req_value1[0 +: W] = 32'h7fc00000;
        req_value2[0 +: W] = 32'h3fc00000;
        @(posedge aclk);
        #1 req_valid = '0;
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (resp_valid !== 4'b0001 || resp_result !== want) begin
            errors++;
            $display("FAIL nan_result: got %b/%h required 0001/%h", resp_valid, resp_result, want);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 4'b0001;
        req_value1[0 +: W] = 32'h40000000;
        req_value2[0 +: W] = 32'h3f800000;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_grant: got %b required 0001", req_ready);
        end
        @(posedge aclk);
        #1 begin req_valid = '0; aresetn = 1'b0; end
        @(negedge aclk);
        checks++;
        if (resp_valid !== '0 || cmp_value1 !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL mid_async: got resp=%b cmp=%h ready=%b required 0", resp_valid,
                     cmp_value1, req_ready);
        end
        @(posedge aclk);
        #1 begin aresetn = 1'b1; req_valid = 4'b1111; end
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            checks++;
            if (req_ready !== (4'(1) << k)) begin
                errors++;
                $display("FAIL mid_ptr k=%0d: got %b required %b", k, req_ready, 4'(1) << k);
            end
            checks++;
            if (k < 2 && resp_valid !== '0) begin
                errors++;
                $display("FAIL mid_no_resp k=%0d: got %b required 0000", k, resp_valid);
            end
            @(posedge aclk);
            #1;
        end
        req_valid = '0;
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        model_reset();
        for (int c = 0; c < 304; c++) begin
            req_valid = (c < 300) ? N'($urandom | (($urandom_range(0, 3) == 0) ? 0 : 32'hF)) : '0;
            if (c < 300 && $urandom_range(0, 2) == 0) req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_value1[i*W +: W] = rand_fp();
                req_value2[i*W +: W] = rand_fp();
            end
            @(negedge aclk);
            model_cycle();
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_ready c=%0d: got %b required %b", c, req_ready, exp_ready);
            end
            checks++;
            if (resp_valid !== exp_rv || resp_id !== 2'(exp_id) || resp_result !== exp_res) begin
                errors++;
                $display("FAIL b2b_resp c=%0d: got %b/%0d/%h required %b/%0d/%h", c, resp_valid,
                         resp_id, resp_result, exp_rv, exp_id, exp_res);
            end
            checks++;
            if (cmp_value1 !== exp_cv1 || cmp_value2 !== exp_cv2) begin
                errors++;
                $display("FAIL b2b_cmp c=%0d: got %h/%h required %h/%h", c, cmp_value1,
                         cmp_value2, exp_cv1, exp_cv2);
            end
            @(posedge aclk);
            #1;
        end
        checks++;
        if (pend_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses outstanding, required 0", pend_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_nan();
        test_reset_midflight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
